// File: rtl/mod_counter_decoder.sv
// Modulo-N up/down step counter with run/one-shot sequencer and one-hot decode of the count.
// Optional DEC_OUT_REG_EN: registers dec_out (one-cycle lag); default build decodes combinationally.
module mod_counter_decoder #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en,
  input  logic               start,
  input  logic               one_shot,
  input  logic               up,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               dec_en,
  output logic [WIDTH-1:0]   val,
  output logic [MODULUS-1:0] dec_out,
  output logic               tc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   val_next;
  logic [WIDTH-1:0]   term;
  logic [WIDTH-1:0]   load_clip;
  logic [WIDTH-1:0]   wrap_val;
  logic               in_range;
  logic               tc_next;
  logic [MODULUS-1:0] dec_c;

  assign term      = up ? MAX_VAL : '0;
  assign wrap_val  = up ? '0 : MAX_VAL;
  assign in_range  = (32'(val) < MODULUS);
  assign load_clip = (32'(load_val) >= MODULUS) ? MAX_VAL : load_val;

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: load overrides the DONE restart and can itself start a run
  always_comb begin
    state_next = state;
    if (load) begin
      if (start)              state_next = RUN;
      else if (state == DONE) state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (en && in_range && (val == term) && one_shot) state_next = DONE;
        DONE:    if (start) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Next count and terminal-count pulse
  always_comb begin
    val_next = val;
    tc_next  = 1'b0;
    if (load) begin
      val_next = load_clip;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (!in_range) begin
              val_next = wrap_val;
            end else if (val == term) begin
              if (!one_shot) val_next = wrap_val;
            end else begin
              val_next = up ? (val + WIDTH'(1)) : (val - WIDTH'(1));
              tc_next  = (val_next == term);
            end
          end
        end
        DONE:    if (start) val_next = wrap_val;
        default: val_next = val;
      endcase
    end
  end

  // Registered outputs; busy/done are decodes of the state being entered
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      val  <= '0;
      tc   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      val  <= val_next;
      tc   <= tc_next;
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

  // One-hot decode of the registered count
  always_comb begin
    dec_c = '0;
    if (dec_en) begin
      for (int unsigned i = 0; i < MODULUS; i++) begin
        dec_c[i] = (32'(val) == i);
      end
    end
  end

`ifdef DEC_OUT_REG_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) dec_out <= '0;
    else       dec_out <= dec_c;
  end
`else
  assign dec_out = dec_c;
`endif

endmodule

// File: tb/tb_mod_counter_decoder.sv
// Randomized and directed bench for mod_counter_decoder (WIDTH=3, MODULUS=6) against an
// arithmetic reference model; honours DEC_OUT_REG_EN for the expected dec_out timing.
module tb_mod_counter_decoder;

  localparam int unsigned W   = 3;
  localparam int unsigned MOD = 6;

  logic           clk = 1'b0;
  logic           clear = 1'b1;
  logic           en = 1'b0, start = 1'b0, one_shot = 1'b0, up = 1'b1, load = 1'b0, dec_en = 1'b0;
  logic [W-1:0]   load_val = '0;
  logic [W-1:0]   val;
  logic [MOD-1:0] dec_out;
  logic           tc, busy, done;

  mod_counter_decoder #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk(clk), .clear(clear), .en(en), .start(start), .one_shot(one_shot), .up(up),
    .load(load), .load_val(load_val), .dec_en(dec_en), .val(val), .dec_out(dec_out),
    .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0=idle, 1=run, 2=done
  int m_state, m_val, m_tc, m_dec_reg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_val = 0; m_tc = 0; m_dec_reg = 0;
  endtask

  // One rising edge with the inputs currently applied
  task automatic model_clock();
    int nv, ns, ntc, tv;
    nv = m_val; ns = m_state; ntc = 0;
    tv = up ? MOD - 1 : 0;
    m_dec_reg = dec_en ? (1 << m_val) : 0;
    if (load) begin
      nv = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
      if (start) ns = 1;
      else if (m_state == 2) ns = 0;
    end else if (m_state == 0) begin
      if (start) ns = 1;
    end else if (m_state == 1) begin
      if (en) begin
        if (one_shot && m_val == tv) ns = 2;
        else begin
          nv  = (m_val + (up ? 1 : MOD - 1)) % MOD;
          ntc = (nv == tv && m_val != tv) ? 1 : 0;
        end
      end
    end else if (start) begin
      ns = 1;
      nv = up ? 0 : MOD - 1;
    end
    m_val = nv; m_state = ns; m_tc = ntc;
  endtask

  task automatic compare_all(input string tag);
    int exp_dec;
`ifdef DEC_OUT_REG_EN
    exp_dec = m_dec_reg;
`else
    exp_dec = dec_en ? (1 << m_val) : 0;
`endif
    check({tag, ".val"},  32'(val),     32'(m_val));
    check({tag, ".tc"},   32'(tc),      32'(m_tc));
    check({tag, ".busy"}, 32'(busy),    32'(m_state == 1));
    check({tag, ".done"}, 32'(done),    32'(m_state == 2));
    check({tag, ".dec"},  32'(dec_out), 32'(exp_dec));
  endtask

  task automatic cyc(input string tag, input logic i_en, input logic i_start, input logic i_os,
                     input logic i_up, input logic i_load, input logic [W-1:0] i_lv,
                     input logic i_de);
    @(negedge clk);
    en = i_en; start = i_start; one_shot = i_os; up = i_up;
    load = i_load; load_val = i_lv; dec_en = i_de;
    @(posedge clk);
    model_clock();
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    clear = 1'b0;

    // Free-running up count with wrap
    cyc("p1_start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) cyc("p1_run", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);

    // One-shot: stop at terminal and hold
    for (int i = 0; i < 16; i++) cyc("p2_run", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    check("p2_val_stop", 32'(val), 32'd5);
    check("p2_done", 32'(done), 32'd1);
    cyc("p2_restart", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    check("p2_restart_val", 32'(val), 32'd0);

    // Down count from a loaded value, then direction change
    cyc("p3_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 4; i++) cyc("p3_down", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    check("p3_val4", 32'(val), 32'd4);
    for (int i = 0; i < 2; i++) cyc("p3_up", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    check("p3_wrap0", 32'(val), 32'd0);

    // Load clipping and priority
    cyc("p4_clip", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1);
    check("p4_clip_val", 32'(val), 32'd5);
    cyc("p4_ldstep", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1);
    check("p4_ldstep_val", 32'(val), 32'd1);
    for (int i = 0; i < 8; i++) cyc("p4_os", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    cyc("p4_ldstart", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
    check("p4_ldstart_val", 32'(val), 32'd3);
    check("p4_ldstart_busy", 32'(busy), 32'd1);

    // Asynchronous clear mid-run
    cyc("p5_ld3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
    @(negedge clk);
    en = 1'b0; load = 1'b0; #2;
    clear = 1'b1;
    model_reset();
    #1;
    compare_all("p5_clear_async");
    @(posedge clk); #1;
    compare_all("p5_clear_held");
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) cyc("p5_idle_en", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    check("p5_stay0", 32'(val), 32'd0);

    // Randomized stimulus, including dec_en toggling
    for (int i = 0; i < 3000; i++) begin
      cyc("rand", ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
          ($urandom % 5) != 0, ($urandom % 12) == 0, W'($urandom % 8), ($urandom % 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter_decoder.md
Name: mod_counter_decoder

Overview:
Parametrised successor to the 3-bit counter/3-to-8 decoder pair. Combines a modulo-N up/down counter with synchronous load and a run/one-shot sequencer FSM. Drives a one-hot decoded output of the current count. Used as a step sequencer / phase selector for datapath control (e.g. selecting one of N register lanes per cycle).

Parameters:
WIDTH, 3, counter width in bits.
MODULUS, 8, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.

Ports:
clk  input  1  rising-edge clock.
clear  input  1  asynchronous reset, active-high.
en  input  1  step enable; counter advances only when en=1 in RUN.
start  input  1  begin/restart counting (single-cycle pulse).
one_shot  input  1  1 = stop at terminal count; 0 = wrap (free-run). Sampled every cycle.
up  input  1  1 = count up, 0 = count down. Sampled on every step.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  load value.
dec_en  input  1  decoder enable.
val  output  WIDTH  current count (registered).
dec_out  output  MODULUS  one-hot decode of val.
tc  output  1  terminal-count pulse (registered, 1 cycle).
busy  output  1  high in RUN.
done  output  1  high in DONE.

Behaviour:
- Reset (clear=1, async): val=0, state=IDLE, tc=0, busy=0, done=0. dec_out=0 if DEC_OUT_REG_EN is defined; otherwise follows the decode rule below.
- Terminal value: MODULUS-1 when up=1; 0 when up=0.
- FSM states are IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE); both are registered state decodes.
- IDLE: val holds. start -> RUN; counting begins from the current val on the next en cycle.
- RUN, en=1, val != terminal: val <= val+1 (up) or val-1 (down).
- RUN, en=1, val == terminal, one_shot=0: wrap. Up: MODULUS-1 -> 0. Down: 0 -> MODULUS-1. State stays RUN.
- RUN, en=1, val == terminal, one_shot=1: val holds; state -> DONE.
- RUN, en=0: val holds. No other effect.
- DONE: val holds. start -> RUN and val <= 0 (up=1) or MODULUS-1 (up=0).
- start in RUN: ignored.
- tc: asserted for exactly one cycle, in the cycle after a step (not a load) lands val on the terminal value.
- Load has priority over any step and over the DONE restart value.
  - val <= load_val. If load_val >= MODULUS, val <= MODULUS-1 (clip).
  - load in DONE moves state to IDLE; load in IDLE or RUN leaves state unchanged.
  - load and start together: val <= load_val (clipped), state -> RUN.
- Direction change mid-run is legal. Terminal is re-evaluated with the current up.
- Out-of-range val is unreachable. If forced by X-prop/fault, the next step wraps to 0 (up) or MODULUS-1 (down).
- Decode: dec_out[i]=1 iff dec_en=1 and val==i. When dec_en=0, dec_out is all zeros (driven, never holds its previous value). All branches are fully assigned; no inferred latches.
- All state elements change only on posedge clk or on clear.

Optional Feature:
DEC_OUT_REG_EN
- Defined: dec_out is registered. It reflects val and dec_en from the previous cycle, so it lags val by 1 cycle. Reset value is 0.
- Undefined: dec_out is combinational from the registered val and the live dec_en, with zero latency.

Test Plan:
1. WIDTH=3, MODULUS=6, up=1, one_shot=0, en=1, dec_en=1, start pulse after reset -> val 0,1,2,3,4,5,0,1. tc high the cycle after val reaches 5. dec_out 000001 -> 100000 -> 000001.
2. MODULUS=6, up=1, one_shot=1, start -> val stops at 5; done=1, busy=0. Holds for 10 en cycles. start again -> val=0, RUN resumes.
3. MODULUS=6, up=0, load_val=2 with load, then start, en=1 -> val 2,1,0,5,4 (free-run). tc after reaching 0. Toggle up=1 at val=4 -> 5, then wrap to 0.
4. load_val=7 with MODULUS=6 -> val=5. Load and en step in the same RUN cycle -> load wins. Load and start in DONE -> val=load_val, state RUN.
5. Assert clear mid-RUN at val=3 -> val=0, state IDLE, tc/busy/done=0 immediately without a clock edge. en pulses after release -> val stays 0 until start.
6. dec_en toggling: dec_en=0 -> dec_out=0. With DEC_OUT_REG_EN defined -> dec_out lags val and dec_en by exactly 1 cycle. Undefined -> same cycle.
